mdu_riscv: RTL and testbench
============================

// Module: mdu_riscv
// PURPOSE
//  Iterative multiply/divide unit for the RV32M extension; sits between the register file read ports and its write port.
//  Consumes rs1/rs2 data, computes over multiple cycles while stalling the core, then returns result plus rd address for write-back.
//  Shift-add multiplier and restoring divider share one XLEN-step datapath.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk_i       in   1     clock, all state on rising edge
//  rst_i       in   1     asynchronous, active-high reset
//  start_i     in   1     request valid; sampled only in IDLE
//  kill_i      in   1     synchronous abort (pipeline flush)
//  op_i        in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  a_i         in   XLEN  rs1 data (register file read_data1)
//  b_i         in   XLEN  rs2 data (register file read_data2)
//  rd_addr_i   in   5     destination register
//  busy_o      out  1     high whenever state != IDLE; core stall
//  done_o      out  1     one-cycle pulse; result valid; drives RF write enable
//  result_o    out  XLEN  result; held stable until next done_o
//  rd_addr_o   out  5     latched rd_addr_i; drives RF write address
// BEHAVIOUR
//  Reset: state IDLE, busy_o=0, done_o=0, result_o=0, rd_addr_o=0, all internal regs 0; rst_i mid-op discards operation, no done_o.
//  FSM: IDLE -> CALC -> FIN -> DONE -> IDLE; fast path IDLE -> DONE.
//  IDLE: on start_i, latch op, rd_addr, |a|,|b| per signedness, result sign; counter=XLEN-1; go CALC.
//   Signed operands: MULH a,b; MULHSU a only; DIV/REM both; MUL sign-agnostic (low half identical).
//  CALC: one multiply or divide step per cycle; counter==0 -> FIN, else counter-1.
//  FIN: apply sign fix (2's complement negate of 2*XLEN product or quotient/remainder), register result_o -> DONE.
//  DONE: done_o=1 for exactly one cycle -> IDLE.
//  Latency: start sampled at edge k, done_o high during cycle k+XLEN+2 (34 for XLEN=32).
//  Product 2*XLEN bits: MUL returns [XLEN-1:0], MULH/MULHSU/MULHU return [2*XLEN-1:XLEN].
//  Remainder sign = dividend sign; quotient truncates toward zero.
//  Fast path (done_o at cycle k+1, no CALC):
//   divide by zero: DIV/DIVU -> all ones; REM/REMU -> a_i.
//   DIV overflow (a=-2^(XLEN-1), b=-1): quotient=a_i; REM -> 0.
//  start_i while busy_o=1: ignored, no queueing.
//  kill_i: any state -> IDLE next edge, done_o suppressed, result_o unchanged; kill_i wins over start_i in IDLE.
//  rd_addr 0: computed normally; x0 write discard is the register file's job.
//  Operands need not be held after the start cycle.
// STRUCTURE
//  Shared package mdu_pkg: mdu_op_e (funct3 encodings), mdu_state_e (IDLE,CALC,FIN,DONE), XLEN default.
//  Single module, no sub-module: shared accumulator/shift register, counter, FSM in one file.
// TESTING
//  MUL a=7,b=0xFFFFFFFD (-3) -> result_o=0xFFFFFFEB, done_o exactly at cycle 34, busy_o high cycles 1..33.
//  MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFFE/2 -> 0x7FFFFFFF; REMU 17/5 -> 2.
//  DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0; each done_o at cycle 1.
//  Start at cycle 0, second start_i at cycle 5 ignored, kill_i at cycle 10 -> busy_o=0 cycle 11, no done_o, result_o unchanged.
//  rst_i asserted mid-CALC (cycle 12, async, between edges) -> busy_o/done_o/result_o/rd_addr_o = 0 immediately; new op after release completes normally.

Source files
------------

// File: rtl/mdu_pkg.sv
// RV32M multiply/divide shared types: funct3 op encodings, FSM states, default width.
package mdu_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIN  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   function automatic logic is_div_op(input mdu_op_e op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/mdu_riscv.sv
// Iterative RV32M MUL/DIV: XLEN shift-add / restoring steps, done_o at k+XLEN+2 (k+1 on div fast path).
// No backpressure: start_i is ignored while busy_o, kill_i aborts any state without a done_o.
module mdu_riscv
   import mdu_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            kill_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  logic [4:0]      rd_addr_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o,
   output logic [4:0]      rd_addr_o
);

   localparam int CW = $clog2(XLEN);

   mdu_state_e      state_q, state_d;
   mdu_op_e         op_q, op_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] opnd_q, opnd_d;
   logic [XLEN-1:0] result_q, result_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            neg_q, neg_d;
   logic [4:0]      rd_q, rd_d;

   mdu_op_e         op_in;
   logic            a_neg, b_neg;
   logic [XLEN-1:0] a_abs, b_abs;
   logic            div_zero, div_ovf;
   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   rem_sh, trial;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0] quo_fix, rem_fix;

   assign op_in = mdu_op_e'(op_i);

   always_comb begin
      a_neg    = (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM}) && a_i[XLEN-1];
      b_neg    = (op_in inside {OP_MULH, OP_DIV, OP_REM}) && b_i[XLEN-1];
      a_abs    = a_neg ? (~a_i + 1'b1) : a_i;
      b_abs    = b_neg ? (~b_i + 1'b1) : b_i;
      div_zero = (b_i == '0);
      div_ovf  = (op_in inside {OP_DIV, OP_REM}) &&
                 (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
   end

   // Multiply: {hi,lo} shifts right, adding opnd (|a|) into hi when lo[0] is set.
   // Divide: {hi,lo} shifts left, hi is the partial remainder, quotient bits enter lo[0].
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh   = {hi_q, lo_q[XLEN-1]};
      trial    = rem_sh - {1'b0, opnd_q};
      prod_fix = neg_q ? (~{hi_q, lo_q} + 1'b1) : {hi_q, lo_q};
      quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
      rem_fix  = neg_q ? (~hi_q + 1'b1) : hi_q;
   end

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      rd_d     = rd_q;

      if (kill_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  op_d  = op_in;
                  rd_d  = rd_addr_i;
                  cnt_d = CW'(XLEN-1);
                  hi_d  = '0;
                  if (is_div_op(op_in)) begin
                     lo_d   = a_abs;
                     opnd_d = b_abs;
                     neg_d  = (op_in == OP_REM) ? a_neg : (a_neg ^ b_neg);
                     if (div_zero) begin
                        result_d = (op_in inside {OP_DIV, OP_DIVU}) ? '1 : a_i;
                        state_d  = ST_DONE;
                     end else if (div_ovf) begin
                        result_d = (op_in == OP_DIV) ? a_i : '0;
                        state_d  = ST_DONE;
                     end else begin
                        state_d = ST_CALC;
                     end
                  end else begin
                     lo_d    = b_abs;
                     opnd_d  = a_abs;
                     neg_d   = a_neg ^ b_neg;
                     state_d = ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               if (is_div_op(op_q)) begin
                  if (!trial[XLEN]) begin
                     hi_d = trial[XLEN-1:0];
                     lo_d = {lo_q[XLEN-2:0], 1'b1};
                  end else begin
                     hi_d = rem_sh[XLEN-1:0];
                     lo_d = {lo_q[XLEN-2:0], 1'b0};
                  end
               end else begin
                  hi_d = mul_sum[XLEN:1];
                  lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
               end
               if (cnt_q == '0) begin
                  state_d = ST_FIN;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            ST_FIN: begin
               case (op_q)
                  OP_MUL:          result_d = prod_fix[XLEN-1:0];
                  OP_DIV, OP_DIVU: result_d = quo_fix;
                  OP_REM, OP_REMU: result_d = rem_fix;
                  default:         result_d = prod_fix[2*XLEN-1:XLEN];
               endcase
               state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_MUL;
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         rd_q     <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         rd_q     <= rd_d;
      end
   end

   // A flush landing in the DONE cycle must still block the register file write.
   assign done_o    = (state_q == ST_DONE) && !kill_i;
   assign busy_o    = (state_q != ST_IDLE);
   assign result_o  = result_q;
   assign rd_addr_o = rd_q;

endmodule

// File: tb/tb_mdu_riscv.sv
// Directed-vector bench for mdu_riscv: results, latency, ignored start, kill and async reset.
module tb_mdu_riscv;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        start_i = 1'b0;
   logic        kill_i = 1'b0;
   logic [2:0]  op_i = 3'd0;
   logic [31:0] a_i = '0;
   logic [31:0] b_i = '0;
   logic [4:0]  rd_addr_i = '0;
   logic        busy_o;
   logic        done_o;
   logic [31:0] result_o;
   logic [4:0]  rd_addr_o;

   int n_vec = 0;
   int n_err = 0;

   mdu_riscv #(.XLEN(32)) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .kill_i    (kill_i),
      .op_i      (op_i),
      .a_i       (a_i),
      .b_i       (b_i),
      .rd_addr_i (rd_addr_i),
      .busy_o    (busy_o),
      .done_o    (done_o),
      .result_o  (result_o),
      .rd_addr_o (rd_addr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Start sampled at the edge after the driving negedge; sample n is cycle n after that edge.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int exp_lat);
      int cyc;
      int busy_cnt;
      @(negedge clk_i);
      op_i = op; a_i = a; b_i = b; rd_addr_i = rd; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      a_i = $urandom; b_i = $urandom; rd_addr_i = 5'($urandom);
      cyc = 1;
      busy_cnt = 0;
      while (!done_o && cyc < 200) begin
         if (busy_o) busy_cnt++;
         @(negedge clk_i);
         cyc++;
      end
      check_val({tag, " latency"}, 32'(cyc), 32'(exp_lat));
      check_val({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
      check_val({tag, " result"}, result_o, exp);
      check_val({tag, " rd"}, 32'(rd_addr_o), 32'(rd));
      @(negedge clk_i);
      check_val({tag, " done pulse"}, 32'(done_o), 32'd0);
      check_val({tag, " idle"}, 32'(busy_o), 32'd0);
   endtask

   initial begin
      int dones;
      repeat (3) @(negedge clk_i);
      check_val("rst busy", 32'(busy_o), 32'd0);
      check_val("rst done", 32'(done_o), 32'd0);
      check_val("rst result", result_o, 32'd0);
      check_val("rst rd", 32'(rd_addr_o), 32'd0);
      rst_i = 1'b0;

      run_op("MUL",    3'd0, 32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 34);
      run_op("MULH",   3'd1, 32'h80000000, 32'h80000000, 5'd2,  32'h40000000, 34);
      run_op("MULHU",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFE, 34);
      run_op("MULHSU", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFF, 34);
      run_op("DIV",    3'd4, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD, 34);
      run_op("REM",    3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF, 34);
      run_op("DIVU",   3'd5, 32'hFFFFFFFE, 32'd2,        5'd7,  32'h7FFFFFFF, 34);
      run_op("REMU",   3'd7, 32'd17,       32'd5,        5'd0,  32'd2,        34);

      // Kill mid-multiply, with a second start ignored at cycle 5.
      @(negedge clk_i);
      op_i = 3'd0; a_i = 32'd3; b_i = 32'd5; rd_addr_i = 5'd9; start_i = 1'b1;
      dones = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk_i);
         if (done_o) dones++;
         start_i = (c == 5);
         op_i    = (c == 5) ? 3'd4 : 3'd0;
         kill_i  = (c == 10);
      end
      @(negedge clk_i);
      kill_i = 1'b0;
      check_val("kill busy", 32'(busy_o), 32'd0);
      for (int c = 0; c < 40; c++) begin
         if (done_o) dones++;
         @(negedge clk_i);
      end
      check_val("kill no done", 32'(dones), 32'd0);
      check_val("kill result held", result_o, 32'd2);
      check_val("kill stays idle", 32'(busy_o), 32'd0);

      run_op("DIV by 0",  3'd4, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 1);
      run_op("REM by 0",  3'd6, 32'd5,        32'd0,        5'd11, 32'd5,        1);
      run_op("DIVU by 0", 3'd5, 32'd9,        32'd0,        5'd12, 32'hFFFFFFFF, 1);
      run_op("REM ovf",   3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        1);
      run_op("DIV ovf",   3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);

      // Async reset in the middle of a divide.
      @(negedge clk_i);
      op_i = 3'd5; a_i = 32'd1000; b_i = 32'd3; rd_addr_i = 5'd21; start_i = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk_i);
         start_i = 1'b0;
      end
      check_val("pre-rst busy", 32'(busy_o), 32'd1);
      #2 rst_i = 1'b1;
      #1;
      check_val("async rst busy", 32'(busy_o), 32'd0);
      check_val("async rst done", 32'(done_o), 32'd0);
      check_val("async rst result", result_o, 32'd0);
      check_val("async rst rd", 32'(rd_addr_o), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      run_op("REMU after rst", 3'd7, 32'd17, 32'd5, 5'd3, 32'd2, 34);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
